// File: rtl/data_memory_pkg.sv
// Shared types and defaults for the byte-lane data memory.
package data_memory_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 256;

  // Access size encodings carried on accessSize.
  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } access_size_e;

  // INIT sweeps the array to zero; READY serves requests until the next reset.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: lane enables, store steering, load extraction
// with sign/zero extension, and misalignment detection. Big-endian lanes:
// lane 0 is the most significant byte of the word. DATA_W must be >= 16.
module mem_lane_align
  import data_memory_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  localparam int NBYTES = DATA_W / 8,
  localparam int OFF_W  = $clog2(NBYTES)
) (
  input  logic [1:0]        i_accessSize,
  input  logic [OFF_W-1:0]  i_byteOffset,
  input  logic [DATA_W-1:0] i_writeData,
  input  logic [DATA_W-1:0] i_rawWord,
  input  logic              i_signedLoad,
  output logic [NBYTES-1:0] o_laneEnable,
  output logic [DATA_W-1:0] o_storeWord,
  output logic [DATA_W-1:0] o_loadData,
  output logic              o_misaligned
);

  access_size_e          w_size;
  logic [OFF_W+2:0]      w_shiftBits;
  logic [DATA_W-1:0]     w_shifted;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_size      = access_size_e'(i_accessSize);
  assign w_shiftBits = {i_byteOffset, 3'b000};
  // Shift the addressed lane(s) up to the top of the word so extraction is a fixed slice.
  assign w_shifted   = i_rawWord << w_shiftBits;
  assign w_byte      = w_shifted[DATA_W-1 -: 8];
  assign w_half      = w_shifted[DATA_W-1 -: 16];

  // Misalignment: halves need an even offset, words need offset 0, size 11 never legal.
  always_comb begin
    o_misaligned = 1'b0;
    case (w_size)
      SIZE_BYTE: o_misaligned = 1'b0;
      SIZE_HALF: o_misaligned = i_byteOffset[0];
      SIZE_WORD: o_misaligned = |i_byteOffset;
      default:   o_misaligned = 1'b1;
    endcase
  end

  // Lane enables and store steering; data is replicated so any enabled lane sees its byte.
  always_comb begin
    o_laneEnable = '0;
    o_storeWord  = i_writeData;
    case (w_size)
      SIZE_BYTE: begin
        o_storeWord = {NBYTES{i_writeData[7:0]}};
        for (int k = 0; k < NBYTES; k++) begin
          o_laneEnable[k] = (int'(i_byteOffset) == k);
        end
      end
      SIZE_HALF: begin
        o_storeWord = {(NBYTES/2){i_writeData[15:0]}};
        for (int k = 0; k < NBYTES; k++) begin
          o_laneEnable[k] = ((int'(i_byteOffset) >> 1) == (k >> 1));
        end
      end
      SIZE_WORD: begin
        o_storeWord  = i_writeData;
        o_laneEnable = '1;
      end
      default: o_laneEnable = '0;
    endcase
    if (o_misaligned) begin
      o_laneEnable = '0;
    end
  end

  // Load extraction: right-justify the selected lanes and extend per signedLoad.
  always_comb begin
    o_loadData = i_rawWord;
    case (w_size)
      SIZE_BYTE: o_loadData = i_signedLoad ? {{(DATA_W-8){w_byte[7]}}, w_byte}
                                           : {{(DATA_W-8){1'b0}}, w_byte};
      SIZE_HALF: o_loadData = i_signedLoad ? {{(DATA_W-16){w_half[15]}}, w_half}
                                           : {{(DATA_W-16){1'b0}}, w_half};
      default:   o_loadData = i_rawWord;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory with registered loads, read-before-write and a
// post-reset clear sweep that holds ready low until every word is zero.
module data_memory_bytelane
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  input  logic              memWriteF,
  input  logic              memReadF,
  input  logic [1:0]        accessSize,
  input  logic              signedLoad,
  output logic [DATA_W-1:0] readData,
  output logic              readValid,
  output logic              misalignFault,
  output logic              ready
);

  localparam int NBYTES = DATA_W / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  mem_state_e        r_state;
  mem_state_e        w_stateNext;
  logic [IDX_W-1:0]  r_initCount;
  logic [IDX_W-1:0]  w_initCountNext;
  logic              w_ready;
  logic              w_clearEn;

  logic [IDX_W-1:0]  w_wordIndex;
  logic [OFF_W-1:0]  w_byteOffset;
  logic [DATA_W-1:0] w_rawWord;
  logic [NBYTES-1:0] w_laneEnable;
  logic [DATA_W-1:0] w_storeWord;
  logic [DATA_W-1:0] w_loadData;
  logic              w_misaligned;
  logic              w_accept;
  logic              w_doWrite;
  logic              w_doRead;

  logic [DATA_W-1:0] r_readData;
  logic              r_readValid;
  logic              r_misalignFault;
  logic              w_unusedAddr;

  // Upper address bits are deliberately ignored so the array wraps modulo DEPTH.
  assign w_unusedAddr = ^address;

  assign w_wordIndex  = address[OFF_W +: IDX_W];
  assign w_byteOffset = address[OFF_W-1:0];
  assign w_rawWord    = r_mem[w_wordIndex];

  mem_lane_align #(
    .DATA_W(DATA_W)
  ) u_laneAlign (
    .i_accessSize (accessSize),
    .i_byteOffset (w_byteOffset),
    .i_writeData  (writeData),
    .i_rawWord    (w_rawWord),
    .i_signedLoad (signedLoad),
    .o_laneEnable (w_laneEnable),
    .o_storeWord  (w_storeWord),
    .o_loadData   (w_loadData),
    .o_misaligned (w_misaligned)
  );

  assign w_accept  = w_ready & (memWriteF | memReadF);
  assign w_doWrite = w_ready & memWriteF & ~w_misaligned;
  assign w_doRead  = w_ready & memReadF & ~w_misaligned;

  // State register and clear-sweep counter; reset always restarts the sweep at word 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_initCount <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_initCount <= w_initCountNext;
    end
  end

  // Next-state logic: clear one word per cycle, move to READY after the last word.
  always_comb begin
    w_stateNext     = r_state;
    w_initCountNext = r_initCount;
    w_ready         = 1'b0;
    w_clearEn       = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clearEn = 1'b1;
        if (r_initCount == IDX_W'(DEPTH - 1)) begin
          w_stateNext = ST_READY;
        end else begin
          w_initCountNext = r_initCount + 1'b1;
        end
      end
      ST_READY: begin
        w_ready = 1'b1;
      end
      default: begin
        w_stateNext     = ST_INIT;
        w_initCountNext = '0;
      end
    endcase
  end

  // Array update: sweep clear during INIT, lane-masked stores once ready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_clearEn) begin
        r_mem[r_initCount] <= '0;
      end else if (w_doWrite) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (w_laneEnable[k]) begin
            r_mem[w_wordIndex][DATA_W-1-8*k -: 8] <= w_storeWord[DATA_W-1-8*k -: 8];
          end
        end
      end
    end
  end

  // Response registers; the load samples the pre-write word, giving read-before-write.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_readData      <= '0;
      r_readValid     <= 1'b0;
      r_misalignFault <= 1'b0;
    end else begin
      r_readValid     <= w_doRead;
      r_misalignFault <= w_accept & w_misaligned;
      if (w_doRead) begin
        r_readData <= w_loadData;
      end
    end
  end

  assign readData      = r_readData;
  assign readValid     = r_readValid;
  assign misalignFault = r_misalignFault;
  assign ready         = w_ready;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor
// pops and compares whenever readValid or misalignFault is presented.
module tb_data_memory_bytelane;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memWriteF;
  logic        memReadF;
  logic [1:0]  accessSize;
  logic        signedLoad;
  logic [31:0] readData;
  logic        readValid;
  logic        misalignFault;
  logic        ready;

  typedef struct {
    bit          isFault;
    logic [31:0] data;
    int          cycle;
    string       name;
  } exp_t;

  exp_t scoreQ[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cycleCount = 0;

  data_memory_bytelane dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .writeData     (writeData),
    .memWriteF     (memWriteF),
    .memReadF      (memReadF),
    .accessSize    (accessSize),
    .signedLoad    (signedLoad),
    .readData      (readData),
    .readValid     (readValid),
    .misalignFault (misalignFault),
    .ready         (ready)
  );

  // 10 time-unit clock and a free-running cycle counter for latency checks.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one request for one cycle; call at posedge+1. Loads and faults queue an expectation.
  task automatic applyStimulus(input string name, input bit rd, input bit wr, input logic [1:0] size,
                               input bit sgn, input logic [31:0] addr, input logic [31:0] data,
                               input bit expFault, input logic [31:0] expData);
    exp_t e;
    address    = addr;
    writeData  = data;
    memReadF   = rd;
    memWriteF  = wr;
    accessSize = size;
    signedLoad = sgn;
    if (rd || expFault) begin
      e.isFault = expFault;
      e.data    = expData;
      e.cycle   = cycleCount + 1;
      e.name    = name;
      scoreQ.push_back(e);
    end
    @(posedge clock);
    #1;
    memReadF  = 1'b0;
    memWriteF = 1'b0;
  endtask

  // Wait a bounded time for outstanding expectations, then require the queue empty.
  task automatic drainQueue(input string name);
    int waitCycles = 0;
    while (scoreQ.size() != 0 && waitCycles < 20) begin
      @(posedge clock);
      waitCycles++;
    end
    checkOutput(name, 32'(scoreQ.size()), 32'd0);
  endtask

  // Check ready stays low for a full sweep then rises; optionally poke a read mid-sweep.
  task automatic checkSweep(input string name, input bit pokeRead);
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      checkOutput($sformatf("%s ready low c%0d", name, i), {31'b0, ready}, 32'd0);
      if (pokeRead) begin
        memReadF   = (i == 50);
        memWriteF  = (i == 50);
        address    = 32'h10;
        writeData  = 32'hCAFEF00D;
        accessSize = 2'b10;
      end
    end
    @(negedge clock);
    checkOutput({name, " ready high"}, {31'b0, ready}, 32'd1);
  endtask

  // Monitor: every presented response must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (readValid || misalignFault)) begin
      if (scoreQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected response: readValid=%0b misalignFault=%0b readData=0x%08h expected no response",
                 readValid, misalignFault, readData);
      end else begin
        e = scoreQ.pop_front();
        checkOutput({e.name, " kind"}, {31'b0, misalignFault}, {31'b0, e.isFault});
        checkOutput({e.name, " valid"}, {31'b0, readValid}, {31'b0, ~e.isFault});
        if (!e.isFault) checkOutput(e.name, readData, e.data);
        checkOutput({e.name, " latency"}, 32'(cycleCount), 32'(e.cycle));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    address    = '0;
    writeData  = '0;
    memWriteF  = 1'b0;
    memReadF   = 1'b0;
    accessSize = 2'b10;
    signedLoad = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("reset readData", readData, 32'd0);
    checkOutput("reset readValid", {31'b0, readValid}, 32'd0);
    checkOutput("reset misalignFault", {31'b0, misalignFault}, 32'd0);
    checkOutput("reset ready", {31'b0, ready}, 32'd0);
    reset = 1'b0;

    // Initial sweep: ready low for 256 cycles, then high.
    checkSweep("init", 1'b0);
    @(posedge clock);
    #1;

    applyStimulus("load 0x40 after init", 1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h00000000);
    applyStimulus("store word 0x10",      0, 1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'h0);
    applyStimulus("load word 0x10",       1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11223344);
    applyStimulus("store byte 0x11",      0, 1, 2'b00, 0, 32'h11, 32'h000000AA, 0, 32'h0);
    applyStimulus("load word after byte", 1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11AA3344);
    applyStimulus("signed byte 0x11",     1, 0, 2'b00, 1, 32'h11, 32'h0, 0, 32'hFFFFFFAA);
    applyStimulus("unsigned byte 0x11",   1, 0, 2'b00, 0, 32'h11, 32'h0, 0, 32'h000000AA);
    applyStimulus("signed half 0x10",     1, 0, 2'b01, 1, 32'h10, 32'h0, 0, 32'h000011AA);
    applyStimulus("misaligned word store",0, 1, 2'b10, 0, 32'h12, 32'hDEADBEEF, 1, 32'h0);
    applyStimulus("load after misalign",  1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11AA3344);
    applyStimulus("read-before-write",    1, 1, 2'b10, 0, 32'h10, 32'h00000055, 0, 32'h11AA3344);
    applyStimulus("load after rbw",       1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h00000055);
    applyStimulus("wrapped load 0x410",   1, 0, 2'b10, 0, 32'h410, 32'h0, 0, 32'h00000055);
    applyStimulus("store half 0x12",      0, 1, 2'b01, 0, 32'h12, 32'h0000BEEF, 0, 32'h0);
    applyStimulus("signed half 0x12",     1, 0, 2'b01, 1, 32'h12, 32'h0, 0, 32'hFFFFBEEF);
    applyStimulus("unsigned half 0x10",   1, 0, 2'b01, 0, 32'h10, 32'h0, 0, 32'h00000000);
    applyStimulus("word after half",      1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h0000BEEF);
    applyStimulus("signed byte 0x13",     1, 0, 2'b00, 1, 32'h13, 32'h0, 0, 32'hFFFFFFEF);
    applyStimulus("misaligned half load", 1, 0, 2'b01, 0, 32'h11, 32'h0, 1, 32'h0);
    applyStimulus("illegal size load",    1, 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0);
    applyStimulus("word unchanged",       1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h0000BEEF);
    drainQueue("drain main");

    // Reset 100 cycles into a sweep, then a full fresh sweep with a request poked in.
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkSweep("mid-sweep reset", 1'b1);
    memReadF  = 1'b0;
    memWriteF = 1'b0;
    @(posedge clock);
    #1;
    applyStimulus("load 0x10 after resweep", 1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h00000000);
    drainQueue("drain final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_bytelane.md
DATA_MEMORY_BYTELANE -- requirements
Module: data_memory_bytelane

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 256, number of words (power of two).
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have port clock, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port address, input, ADDR_W, byte address.
REQ-007 SHALL have port writeData, input, DATA_W, store data, right-justified for sub-word stores.
REQ-008 SHALL have port memWriteF, input, 1, store request.
REQ-009 SHALL have port memReadF, input, 1, load request.
REQ-010 SHALL have port accessSize, input, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port signedLoad, input, 1, load type: 1 sign-extends, 0 zero-extends sub-word loads.
REQ-012 SHALL have port readData, output, DATA_W, registered load result.
REQ-013 SHALL have port readValid, output, 1, one-cycle pulse qualifying readData.
REQ-014 SHALL have port misalignFault, output, 1, one-cycle pulse for a rejected access.
REQ-015 SHALL have port ready, output, 1, high when requests are accepted.

Function
REQ-016 SHALL index words by address[log2(DATA_W/8)+:log2(DEPTH)]; higher address bits ignored (address wraps modulo DEPTH words).
REQ-017 SHALL use big-endian lane order: byte offset 0 is bits [DATA_W-1:DATA_W-8].
REQ-018 SHALL write only the addressed lanes (1, 2 or all bytes) on the rising edge where ready=1, memWriteF=1 and the access is aligned; other lanes keep their value.
REQ-019 SHALL register loads: request accepted at edge N gives readData and readValid=1 after edge N, for exactly one cycle.
REQ-020 SHALL right-justify sub-word loads and extend per signedLoad.
REQ-021 SHALL leave readData holding its last value while readValid=0.
REQ-022 SHALL treat a half access with address[0]=1, a word access with address[1:0]!=0, or accessSize=11 as misaligned.
REQ-023 SHALL not modify memory for a misaligned access, and SHALL not pulse readValid for one.
REQ-024 SHALL pulse misalignFault for one cycle after a misaligned access.
REQ-025 SHALL, when memWriteF and memReadF are both high at one address, write and return the pre-write word (read-before-write).
REQ-026 SHALL ignore all requests while ready=0, with no write, readValid or misalignFault.
REQ-027 SHALL implement a two-state FSM: INIT clears one word per cycle, with a counter running 0..DEPTH-1, and ready=0; after the last word it goes to READY with ready=1, which holds until the next reset.

Reset
REQ-028 SHALL, on reset, set readData=0, readValid=0, misalignFault=0, ready=0, and FSM=INIT with the counter at 0.
REQ-029 SHALL restart the clear sweep from word 0 on reset asserted mid-sweep or mid-operation; pending loads are dropped.
REQ-030 SHALL have ready go high exactly DEPTH cycles after reset deasserts.

Structure
REQ-031 SHALL place the accessSize encodings, FSM state encodings and the default DEPTH/DATA_W in shared package data_memory_pkg.
REQ-032 SHALL use one combinational sub-module, mem_lane_align, for lane-enable generation, store steering, load extraction/extension and misalign detection.

Verification
REQ-033 SHALL cover init: reset 1 cycle, DEPTH=256 -> ready=0 for 256 cycles, then 1; a word load at 0x40 returns 0x00000000.
REQ-034 SHALL cover a word store and load: store 0x11223344 @0x10, load word @0x10 -> readData=0x11223344, readValid one cycle after the request.
REQ-035 SHALL cover byte lanes: after REQ-034, store byte 0xAA @0x11, then load word @0x10 -> 0x11AA3344; signed byte load @0x11 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-036 SHALL cover misalignment: word store @0x12 with data 0xDEADBEEF -> misalignFault pulse, no readValid; word load @0x10 still -> 0x11AA3344.
REQ-037 SHALL cover read-before-write and wrap: simultaneous word load+store 0x55 @0x10 -> readData=0x11AA3344, next load -> 0x00000055; word load @0x410 (DEPTH=256) -> 0x00000055.
REQ-038 SHALL cover reset mid-sweep: reset at cycle 100 of INIT -> ready stays 0 for 256 further cycles; a request during the sweep produces no response.
